result_streamer: RTL and testbench
==================================

Name: result_streamer

Overview:
- Downstream consumer of the 9-entry result memory bank; on a start request it snapshots all result bytes and streams them out one element per beat over a valid/ready interface.
- Each beat carries the element's row/column coordinates.
- Optional sparse mode emits only nonzero elements and reports the nonzero count, feeding display/UART/host-readout logic.

Parameters:
- DIM, 3, matrix dimension; row and column each range 0..DIM-1.
- N_ELEM, DIM*DIM (9), number of result elements; element k maps to row = k / DIM, col = k % DIM.
- DW, 8, data width of each element.
- IW, $clog2(DIM) (2), width of row/col index outputs.
- CW, $clog2(N_ELEM+1) (4), width of nonzero counter.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- start  in  1  request a readout; sampled only in IDLE.
- skip_zero  in  1  sparse mode select; sampled together with start.
- in_data  in  N_ELEM x DW  result bank contents (element k = in_data[k]).
- out_valid  out  1  beat present on out_data/out_row/out_col/out_last.
- out_ready  in  1  downstream accepts beat.
- out_data  out  DW  element value.
- out_row  out  IW  row index of element.
- out_col  out  IW  column index of element.
- out_last  out  1  final beat of this readout.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse at end of readout.
- nnz  out  CW  beats transferred in most recent readout; held until next start.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, out_valid=0, out_last=0, busy=0, done=0, nnz=0, index=0, snapshot and mask cleared. Outputs stay at these values until the first rising edge after reset deasserts.
- States: IDLE, SEND, DONE.
- IDLE, edge with start=1:
  - Capture in_data into the snapshot register.
  - Latch skip_zero into a mode register.
  - Build the send mask: all ones in dense mode; bit k = (in_data[k] != 0) in sparse mode.
  - Clear the beat counter.
  - Set index to the lowest set mask bit.
  - Next state is SEND, or DONE if the mask is zero (sparse mode, all elements zero).
- IDLE, start=0: remain in IDLE; in_data changes are ignored.
- SEND:
  - out_valid=1.
  - out_data = snapshot[index]; out_row/out_col derived from index.
  - out_last=1 iff no set mask bit exists above index.
  - Outputs are driven from registers only; no combinational path from out_ready to any output.
- Transfer occurs on an edge with out_valid & out_ready:
  - Beat counter increments.
  - If out_last: go to DONE. Otherwise index moves to the next set mask bit above index (skipping gaps in one cycle).
- Backpressure: while out_ready=0, all out_* signals hold stable. Valid never drops before the beat is accepted.
- Throughput: one beat per cycle while out_ready=1. Latency start-edge to first out_valid is 1 cycle.
- DONE: lasts exactly one cycle.
  - done=1, busy=1, out_valid=0.
  - nnz takes the final beat count on entry to DONE.
  - Next state is IDLE.
- start asserted in SEND or DONE is ignored; it is not queued.
- skip_zero and in_data changes during a readout have no effect, since the snapshot is already taken.
- Dense-mode readout always yields N_ELEM beats, so nnz=N_ELEM.
- Reset asserted mid-readout aborts immediately with all outputs at reset values; no done pulse.

Decomposition:
- Shared package: state enum (IDLE/SEND/DONE), DIM/N_ELEM/DW defaults, element typedef logic [DW-1:0].
- One natural sub-module: next_set_bit. Combinational priority finder that, given mask and current index, returns the next higher set bit and a none_left flag. It is used for both the initial index and the advance.

Test Plan:
- Dense, out_ready=1, in_data = 1..9 → beats (0,0,1),(0,1,2),…,(2,2,9) on 9 consecutive cycles; out_last only on the 9th; done one cycle later; nnz=9.
- Sparse, in_data = {0,5,0,0,7,0,0,0,3} (k=0..8) → 3 beats: (0,1,5),(1,1,7),(2,2,3); out_last on (2,2,3); nnz=3.
- Sparse, all zero → no out_valid; done pulses 1 cycle after start edge; nnz=0; busy high for exactly 1 cycle.
- Backpressure: dense, out_ready low for 4 cycles at beat 3 → out_data=3 and (0,2) held stable throughout; sequence otherwise intact; nnz=9.
- Start during SEND plus in_data change mid-stream → no restart; emitted values match the snapshot from the original start.
- reset=0 asynchronously at beat 5 → out_valid=0 and busy=0 before the next clock edge; no done pulse; nnz=0; a subsequent start behaves normally.

Source files
------------

// File: rtl/result_streamer_pkg.sv
// Shared types and sizing for the result bank readout streamer.
// Element k of the bank sits at row k / DIM, column k % DIM.
package result_streamer_pkg;

  localparam int DIM    = 3;
  localparam int N_ELEM = DIM * DIM;
  localparam int DW     = 8;
  localparam int IW     = $clog2(DIM);
  localparam int CW     = $clog2(N_ELEM + 1);
  localparam int XW     = $clog2(N_ELEM);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef logic [DW-1:0] elem_t;

  function automatic logic [IW-1:0] row_of(input logic [XW-1:0] k);
    return IW'(int'(k) / DIM);
  endfunction

  function automatic logic [IW-1:0] col_of(input logic [XW-1:0] k);
    return IW'(int'(k) % DIM);
  endfunction

endpackage

// File: rtl/result_streamer_next_set_bit.sv
// Priority finder: lowest set mask bit above index (or at index when inclusive).
// none_left is high when no such bit exists; next_idx is then zero.
module result_streamer_next_set_bit
  import result_streamer_pkg::*;
#(
  parameter int N = N_ELEM,
  parameter int W = XW
) (
  input  logic [N-1:0] mask,
  input  logic [W-1:0] index,
  input  logic         inclusive,
  output logic [W-1:0] next_idx,
  output logic         none_left
);

  logic [N-1:0] qual;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_qual
      assign qual[gi] = mask[gi] & ((W'(gi) > index) | (inclusive & (W'(gi) == index)));
    end
  endgenerate

  // Scan from the top so the lowest qualifying bit is the last one written.
  always_comb begin
    next_idx  = '0;
    none_left = 1'b1;
    for (int i = N - 1; i >= 0; i--) begin
      if (qual[i]) begin
        next_idx  = W'(i);
        none_left = 1'b0;
      end
    end
  end

endmodule

// File: rtl/result_streamer.sv
// Snapshots the result bank on start and streams it out one element per beat,
// optionally skipping zero elements, with row/col tags and a beat count.
module result_streamer
  import result_streamer_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       skip_zero,
  input  logic [N_ELEM-1:0][DW-1:0]  in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DW-1:0]              out_data,
  output logic [IW-1:0]              out_row,
  output logic [IW-1:0]              out_col,
  output logic                       out_last,
  output logic                       busy,
  output logic                       done,
  output logic [CW-1:0]              nnz
);

  state_t                     state_reg, state_next;
  logic [N_ELEM-1:0][DW-1:0]  snap_reg, snap_next;
  logic [N_ELEM-1:0]          mask_reg, mask_next;
  logic [XW-1:0]              index_reg, index_next;
  logic                       last_reg, last_next;
  logic [CW-1:0]              cnt_reg, cnt_next;
  logic [CW-1:0]              nnz_reg, nnz_next;

  logic [N_ELEM-1:0]          nz_vec;
  logic [N_ELEM-1:0]          mask_new;
  logic                       idle;
  logic [N_ELEM-1:0]          find_mask;
  logic [XW-1:0]              find_index;
  logic [XW-1:0]              find_idx;
  logic                       find_none;
  logic [XW-1:0]              after_idx;
  logic                       after_none;

  generate
    for (genvar gi = 0; gi < N_ELEM; gi++) begin : g_nz
      assign nz_vec[gi] = |in_data[gi];
    end
  endgenerate

  // The skip_zero choice is folded into the mask at capture time, so later
  // changes on skip_zero cannot affect the readout in flight.
  assign mask_new = skip_zero ? nz_vec : '1;
  assign idle     = (state_reg == ST_IDLE);

  // In IDLE the finder locates the first beat; in SEND it locates the next.
  assign find_mask  = idle ? mask_new : mask_reg;
  assign find_index = idle ? '0 : index_reg;

  result_streamer_next_set_bit #(.N(N_ELEM), .W(XW)) u_find (
    .mask      (find_mask),
    .index     (find_index),
    .inclusive (idle),
    .next_idx  (find_idx),
    .none_left (find_none)
  );

  // Looks one bit past the chosen index so out_last can be registered.
  result_streamer_next_set_bit #(.N(N_ELEM), .W(XW)) u_after (
    .mask      (find_mask),
    .index     (find_idx),
    .inclusive (1'b0),
    .next_idx  (after_idx),
    .none_left (after_none)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      snap_reg  <= '0;
      mask_reg  <= '0;
      index_reg <= '0;
      last_reg  <= 1'b0;
      cnt_reg   <= '0;
      nnz_reg   <= '0;
    end else begin
      state_reg <= state_next;
      snap_reg  <= snap_next;
      mask_reg  <= mask_next;
      index_reg <= index_next;
      last_reg  <= last_next;
      cnt_reg   <= cnt_next;
      nnz_reg   <= nnz_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    snap_next  = snap_reg;
    mask_next  = mask_reg;
    index_next = index_reg;
    last_next  = last_reg;
    cnt_next   = cnt_reg;
    nnz_next   = nnz_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          snap_next  = in_data;
          mask_next  = mask_new;
          cnt_next   = '0;
          index_next = find_idx;
          last_next  = after_none;
          if (find_none) begin
            state_next = ST_DONE;
            nnz_next   = '0;
          end else begin
            state_next = ST_SEND;
          end
        end
      end
      ST_SEND: begin
        if (out_ready) begin
          cnt_next = cnt_reg + CW'(1);
          if (last_reg) begin
            state_next = ST_DONE;
            nnz_next   = cnt_reg + CW'(1);
          end else begin
            index_next = find_idx;
            last_next  = after_none;
          end
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign out_valid = (state_reg == ST_SEND);
  assign out_data  = snap_reg[index_reg];
  assign out_row   = row_of(index_reg);
  assign out_col   = col_of(index_reg);
  assign out_last  = last_reg & out_valid;
  assign busy      = !idle;
  assign done      = (state_reg == ST_DONE);
  assign nnz       = nnz_reg;

endmodule

// File: tb/tb_result_streamer.sv
// Scenario-driven bench for result_streamer with a queue-based reference model.
module tb_result_streamer;
  import result_streamer_pkg::*;

  typedef logic [N_ELEM-1:0][DW-1:0] bank_t;
  typedef struct packed {
    logic [DW-1:0] data;
    logic [IW-1:0] row;
    logic [IW-1:0] col;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          skip_zero;
  bank_t         in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [IW-1:0] out_row;
  logic [IW-1:0] out_col;
  logic          out_last;
  logic          busy;
  logic          done;
  logic [CW-1:0] nnz;

  always #5 clk = ~clk;

  result_streamer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .skip_zero (skip_zero),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_row   (out_row),
    .out_col   (out_col),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .nnz       (nnz)
  );

  beat_t got_q[$];
  beat_t exp_q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    done_pulses, done_cyc, busy_cycles, first_valid, nnz_seen;
  bit    stable_ok, timed_out;

  // Reference: walk elements in index order, keep all (dense) or nonzero (sparse).
  function automatic void model(input bank_t d, input bit sz);
    beat_t b;
    exp_q.delete();
    for (int k = 0; k < N_ELEM; k++) begin
      if (!sz || d[k] != 0) begin
        b.data = d[k];
        b.row  = IW'(k / DIM);
        b.col  = IW'(k % DIM);
        b.last = 1'b0;
        exp_q.push_back(b);
      end
    end
    if (exp_q.size() > 0) exp_q[exp_q.size()-1].last = 1'b1;
  endfunction

  function automatic bank_t seq_bank();
    bank_t d;
    for (int k = 0; k < N_ELEM; k++) d[k] = DW'(k + 1);
    return d;
  endfunction

  function automatic bank_t rand_bank(input int zero_pct);
    bank_t d;
    for (int k = 0; k < N_ELEM; k++)
      d[k] = ($urandom_range(0, 99) < zero_pct) ? 8'h00 : DW'($urandom_range(1, 255));
    return d;
  endfunction

  // Drives one readout and records what the DUT emitted; tasks judge the results.
  task automatic run_readout(input bank_t d, input bit sz, input bit rnd_ready,
                             input int stall_at, input int stall_len, input bit disturb);
    beat_t cur, held;
    bit    hold, finished;
    int    stall_cnt;
    got_q.delete();
    done_pulses = 0; done_cyc = -1; busy_cycles = 0; first_valid = -1;
    nnz_seen = -1; stable_ok = 1'b1; timed_out = 1'b0;
    hold = 1'b0; finished = 1'b0; stall_cnt = 0;
    @(negedge clk);
    in_data = d; skip_zero = sz; start = 1'b1; out_ready = 1'b1;
    for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      cur = '{out_data, out_row, out_col, out_last};
      if (hold && (!out_valid || cur !== held)) stable_ok = 1'b0;
      if (busy) busy_cycles++;
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (done) begin
        done_pulses++;
        done_cyc = cyc;
        nnz_seen = int'(nnz);
      end
      if (disturb && cyc == 2) begin
        start = 1'b1;
        in_data = rand_bank(30);
        skip_zero = ~sz;
      end
      if (out_valid && got_q.size() == stall_at && stall_cnt < stall_len) begin
        out_ready = 1'b0;
        stall_cnt++;
      end else begin
        out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      if (out_valid && out_ready) begin
        got_q.push_back(cur);
        hold = 1'b0;
      end else if (out_valid) begin
        hold = 1'b1;
        held = cur;
      end else begin
        hold = 1'b0;
      end
      if (!busy && done_pulses > 0) finished = 1'b1;
    end
    start = 1'b0;
    out_ready = 1'b1;
    if (!finished) timed_out = 1'b1;
    $display("readout sparse=%0b beats=%0d done_pulses=%0d nnz=%0d busy_cycles=%0d timeout=%0b",
             sz, got_q.size(), done_pulses, nnz_seen, busy_cycles, timed_out);
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; skip_zero = 1'b0; out_ready = 1'b0; in_data = '0;
    #2;
    n_cmp++;
    if ({out_valid, out_last, busy, done, nnz} !== '0) begin
      n_err++;
      $display("FAIL reset_async: got v=%b l=%b b=%b d=%b nnz=%0d want all 0",
               out_valid, out_last, busy, done, nnz);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({out_valid, out_last, busy, done, nnz} !== '0) begin
      n_err++;
      $display("FAIL reset_idle: got v=%b l=%b b=%b d=%b nnz=%0d want all 0",
               out_valid, out_last, busy, done, nnz);
    end
  endtask

  task automatic test_dense();
    bank_t d;
    for (int t = 0; t < 3; t++) begin
      d = (t == 0) ? seq_bank() : rand_bank(20);
      model(d, 1'b0);
      run_readout(d, 1'b0, t == 2, -1, 0, 1'b0);
      n_cmp++;
      if (timed_out || got_q.size() != exp_q.size()) begin
        n_err++;
        $display("FAIL dense_count[%0d]: got %0d beats want %0d", t, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
        n_cmp++;
        if (got_q[i] !== exp_q[i]) begin
          n_err++;
          $display("FAIL dense_beat[%0d.%0d]: got %h want %h", t, i, got_q[i], exp_q[i]);
        end
      end
      n_cmp++;
      if (nnz_seen != N_ELEM || done_pulses != 1) begin
        n_err++;
        $display("FAIL dense_nnz[%0d]: got nnz=%0d pulses=%0d want nnz=%0d pulses=1",
                 t, nnz_seen, done_pulses, N_ELEM);
      end
      if (t < 2) begin
        n_cmp++;
        if (first_valid != 0 || done_cyc != N_ELEM) begin
          n_err++;
          $display("FAIL dense_timing[%0d]: got first=%0d done=%0d want first=0 done=%0d",
                   t, first_valid, done_cyc, N_ELEM);
        end
      end
    end
  endtask

  task automatic test_sparse();
    bank_t d;
    for (int t = 0; t < 4; t++) begin
      if (t == 0) begin
        d = '0;
        d[1] = 8'd5; d[4] = 8'd7; d[8] = 8'd3;
      end else begin
        d = rand_bank(50);
      end
      model(d, 1'b1);
      run_readout(d, 1'b1, t >= 2, -1, 0, 1'b0);
      n_cmp++;
      if (timed_out || got_q.size() != exp_q.size()) begin
        n_err++;
        $display("FAIL sparse_count[%0d]: got %0d beats want %0d", t, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
        n_cmp++;
        if (got_q[i] !== exp_q[i]) begin
          n_err++;
          $display("FAIL sparse_beat[%0d.%0d]: got %h want %h", t, i, got_q[i], exp_q[i]);
        end
      end
      n_cmp++;
      if (nnz_seen != exp_q.size() || done_pulses != 1) begin
        n_err++;
        $display("FAIL sparse_nnz[%0d]: got nnz=%0d pulses=%0d want nnz=%0d pulses=1",
                 t, nnz_seen, done_pulses, exp_q.size());
      end
    end
  endtask

  task automatic test_all_zero();
    run_readout('0, 1'b1, 1'b0, -1, 0, 1'b0);
    n_cmp++;
    if (timed_out || got_q.size() != 0 || first_valid != -1) begin
      n_err++;
      $display("FAIL zero_beats: got %0d beats first_valid=%0d want 0 beats none",
               got_q.size(), first_valid);
    end
    n_cmp++;
    if (done_cyc != 0 || busy_cycles != 1 || nnz_seen != 0 || done_pulses != 1) begin
      n_err++;
      $display("FAIL zero_done: got done_cyc=%0d busy=%0d nnz=%0d pulses=%0d want 0/1/0/1",
               done_cyc, busy_cycles, nnz_seen, done_pulses);
    end
  endtask

  task automatic test_backpressure();
    bank_t d;
    d = seq_bank();
    model(d, 1'b0);
    run_readout(d, 1'b0, 1'b0, 2, 4, 1'b0);
    n_cmp++;
    if (!stable_ok) begin
      n_err++;
      $display("FAIL bp_stable: got outputs changing under stall want held");
    end
    n_cmp++;
    if (timed_out || got_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL bp_count: got %0d beats want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL bp_beat[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (nnz_seen != N_ELEM || done_cyc != N_ELEM + 4) begin
      n_err++;
      $display("FAIL bp_done: got nnz=%0d done_cyc=%0d want nnz=%0d done_cyc=%0d",
               nnz_seen, done_cyc, N_ELEM, N_ELEM + 4);
    end
    d = rand_bank(40);
    model(d, 1'b1);
    run_readout(d, 1'b1, 1'b1, 0, 3, 1'b0);
    n_cmp++;
    if (!stable_ok || got_q.size() != exp_q.size() || nnz_seen != exp_q.size()) begin
      n_err++;
      $display("FAIL bp_rand: got stable=%0b beats=%0d nnz=%0d want 1/%0d/%0d",
               stable_ok, got_q.size(), nnz_seen, exp_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL bp_rand_beat[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_start_during_send();
    bank_t d;
    d = rand_bank(30);
    model(d, 1'b0);
    run_readout(d, 1'b0, 1'b0, -1, 0, 1'b1);
    n_cmp++;
    if (timed_out || got_q.size() != exp_q.size() || done_pulses != 1) begin
      n_err++;
      $display("FAIL restart_count: got %0d beats %0d pulses want %0d beats 1 pulse",
               got_q.size(), done_pulses, exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL restart_beat[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bank_t d;
    bit    found;
    int    seen_done;
    found = 1'b0; seen_done = 0;
    @(negedge clk);
    in_data = seq_bank(); skip_zero = 1'b0; start = 1'b1; out_ready = 1'b1;
    for (int cyc = 0; cyc < 20 && !found; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (out_valid && out_data == 8'd5) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin
      n_err++;
      $display("FAIL midreset_reach: got no beat 5 within budget want beat 5");
    end
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_async: got v=%b b=%b l=%b want 0/0/0", out_valid, busy, out_last);
    end
    repeat (3) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    n_cmp++;
    if (seen_done != 0 || nnz !== '0) begin
      n_err++;
      $display("FAIL midreset_state: got done_cycles=%0d nnz=%0d want 0/0", seen_done, nnz);
    end
    reset = 1'b1;
    d = rand_bank(10);
    model(d, 1'b0);
    run_readout(d, 1'b0, 1'b1, -1, 0, 1'b0);
    n_cmp++;
    if (timed_out || got_q.size() != exp_q.size() || nnz_seen != N_ELEM) begin
      n_err++;
      $display("FAIL midreset_after: got %0d beats nnz=%0d want %0d beats nnz=%0d",
               got_q.size(), nnz_seen, exp_q.size(), N_ELEM);
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL midreset_beat[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_dense();
    test_sparse();
    test_all_zero();
    test_backpressure();
    test_start_during_send();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
